// File: rtl/vga_frame_scan.sv
// 160x120x3 frame store with 4x-scaled 640x480@60 VGA scan-out and a pixel-plot write port.
// Optional `VGA_FRAME_CLEAR_EN: clears the store to black after every reset (busy high meanwhile).
module vga_frame_scan #(
  parameter int H_VIS      = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VIS      = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SCALE_LOG2 = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       writeEn,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       frame_start,
  output logic       busy
);

  localparam int ADDR_W   = 15;
  localparam int H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FB_W     = H_VIS >> SCALE_LOG2;
  localparam int FB_H     = V_VIS >> SCALE_LOG2;
  localparam int FB_DEPTH = FB_W * FB_H;

  localparam logic [9:0] H_LAST    = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS_C   = 10'(H_VIS);
  localparam logic [9:0] V_VIS_C   = 10'(V_VIS);
  localparam logic [9:0] HS_START  = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END    = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_START  = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END    = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [7:0] FB_W_C    = 8'(FB_W);
  localparam logic [6:0] FB_H_C    = 7'(FB_H);

  function automatic logic [7:0] expand(input logic b);
    return {8{b}};
  endfunction

  logic              pix_en;
  logic [9:0]        h_cnt;
  logic [9:0]        v_cnt;
  logic              vis;
  logic              hs_raw;
  logic              vs_raw;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic              plot_we;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        mem_data;
  logic [2:0]        mem [FB_DEPTH];
  logic [2:0]        pix_p1;
  logic              vis_p1;
  logic              hs_p1;
  logic              vs_p1;

  // Pixel-rate timing: counters step on every other clk
  always_ff @(posedge clk) begin
    if (!reset) begin
      pix_en <= 1'b0;
      h_cnt  <= '0;
      v_cnt  <= '0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

  assign vis         = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
  assign hs_raw      = !((h_cnt >= HS_START) && (h_cnt < HS_END));
  assign vs_raw      = !((v_cnt >= VS_START) && (v_cnt < VS_END));
  assign frame_start = pix_en && (h_cnt == 10'd0) && (v_cnt == 10'd0);

  always_comb begin
    rd_addr = '0;
    if (vis)
      rd_addr = ADDR_W'(v_cnt >> SCALE_LOG2) * ADDR_W'(FB_W) + ADDR_W'(h_cnt >> SCALE_LOG2);
  end

  assign wr_addr = ADDR_W'(y) * ADDR_W'(FB_W) + ADDR_W'(x);
  assign plot_we = writeEn && (x < FB_W_C) && (y < FB_H_C);

`ifdef VGA_FRAME_CLEAR_EN
  typedef enum logic {IDLE, CLEAR} clr_state_t;

  clr_state_t        clr_state;
  logic              clr_arm;
  logic              clr_busy;
  logic [ADDR_W-1:0] clr_addr;

  // Reset arms the sweep; it starts on the first clk out of reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      clr_state <= IDLE;
      clr_arm   <= 1'b1;
      clr_busy  <= 1'b0;
      clr_addr  <= '0;
    end else begin
      case (clr_state)
        IDLE: begin
          if (clr_arm) begin
            clr_state <= CLEAR;
            clr_arm   <= 1'b0;
            clr_busy  <= 1'b1;
            clr_addr  <= '0;
          end
        end
        CLEAR: begin
          if (clr_addr == ADDR_W'(FB_DEPTH - 1)) begin
            clr_state <= IDLE;
            clr_busy  <= 1'b0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        default: clr_state <= IDLE;
      endcase
    end
  end

  assign busy = clr_busy;

  always_comb begin
    mem_we   = plot_we;
    mem_addr = wr_addr;
    mem_data = colour;
    if (clr_busy) begin
      mem_we   = 1'b1;
      mem_addr = clr_addr;
      mem_data = 3'b000;
    end
  end
`else
  assign busy = 1'b0;

  always_comb begin
    mem_we   = plot_we;
    mem_addr = wr_addr;
    mem_data = colour;
  end
`endif

  // Stage p1: registered store read (old data on a same-address write)
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_addr] <= mem_data;
    pix_p1 <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vis_p1      <= 1'b0;
      hs_p1       <= 1'b1;
      vs_p1       <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
    end else begin
      vis_p1      <= vis;
      hs_p1       <= hs_raw;
      vs_p1       <= vs_raw;
      // Stage p2: pins, colour forced black when blanked
      vga_blank_n <= vis_p1;
      vga_hs      <= hs_p1;
      vga_vs      <= vs_p1;
      vga_r       <= vis_p1 ? expand(pix_p1[2]) : 8'h00;
      vga_g       <= vis_p1 ? expand(pix_p1[1]) : 8'h00;
      vga_b       <= vis_p1 ? expand(pix_p1[0]) : 8'h00;
    end
  end

endmodule

// File: tb/tb_vga_frame_scan.sv
// Directed bench for vga_frame_scan: plot table checked against scan-out, sync timing, reset and clear.
module tb_vga_frame_scan;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] x = '0;
  logic [6:0] y = '0;
  logic [2:0] colour = '0;
  logic       writeEn = 1'b0;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_blank_n, frame_start, busy;

  vga_frame_scan dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .colour(colour), .writeEn(writeEn),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n), .frame_start(frame_start), .busy(busy)
  );

  always #5 clk = ~clk;

  // Clocks since reset release; the first clk with reset high is 1
  int cyc = 0;
  always @(posedge clk) begin
    if (!reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [7:0]  px;
    logic [6:0]  py;
    logic [2:0]  pc;
    int          h;
    int          v;
    logic [23:0] rgb;
    logic        bn;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic plot(input logic [7:0] px, input logic [6:0] py, input logic [2:0] pc);
    x = px; y = py; colour = pc; writeEn = 1'b1;
    @(negedge clk);
    writeEn = 1'b0;
  endtask

  function automatic int pix_cyc(input int h, input int v);
    return 2 * (v * 800 + h) + 2;
  endfunction

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int first_low, low_cnt, vs_low, c_wr;
    int nz, bc, guard;

    tbl[0]  = '{8'd0,   7'd0,   3'b010, 1,   0,  24'h00FF00, 1'b1};
    tbl[1]  = '{8'd0,   7'd120, 3'b111, 2,   0,  24'h00FF00, 1'b1};
    tbl[2]  = '{8'd11,  7'd0,   3'b011, 44,  0,  24'h00FFFF, 1'b1};
    tbl[3]  = '{8'd10,  7'd0,   3'b110, 41,  1,  24'hFFFF00, 1'b1};
    tbl[4]  = '{8'd0,   7'd1,   3'b001, 1,   4,  24'h0000FF, 1'b1};
    tbl[5]  = '{8'd160, 7'd0,   3'b111, 3,   5,  24'h0000FF, 1'b1};
    tbl[6]  = '{8'd5,   7'd1,   3'b000, 21,  7,  24'h000000, 1'b1};
    tbl[7]  = '{8'd4,   7'd2,   3'b000, 19,  8,  24'h000000, 1'b1};
    tbl[8]  = '{8'd5,   7'd2,   3'b101, 20,  8,  24'hFF00FF, 1'b1};
    tbl[9]  = '{8'd6,   7'd2,   3'b000, 24,  8,  24'h000000, 1'b1};
    tbl[10] = '{8'd255, 7'd127, 3'b111, 23,  11, 24'hFF00FF, 1'b1};
    tbl[11] = '{8'd5,   7'd3,   3'b000, 22,  12, 24'h000000, 1'b1};
    tbl[12] = '{8'd159, 7'd3,   3'b100, 639, 13, 24'hFF0000, 1'b1};
    tbl[13] = '{8'd200, 7'd50,  3'b111, 640, 13, 24'h000000, 1'b0};

    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rgb", {vga_r, vga_g, vga_b}, 24'h0);
    check("rst_hs", vga_hs, 1'b1);
    check("rst_vs", vga_vs, 1'b1);
    check("rst_blank_n", vga_blank_n, 1'b0);
    check("rst_frame_start", frame_start, 1'b0);
    check("rst_busy", busy, 1'b0);

    // Load the store while timing is held in reset
    for (int i = 0; i < 14; i++) plot(tbl[i].px, tbl[i].py, tbl[i].pc);
    plot(8'd20, 7'd4, 3'b000);

    reset = 1'b1;
    @(negedge clk);
    check("rel_frame_start", frame_start, 1'b1);
    check("rel_blank_n_c1", vga_blank_n, 1'b0);
    @(negedge clk);
    check("rel_frame_start_c2", frame_start, 1'b0);
    check("rel_blank_n_c2", vga_blank_n, 1'b1);

`ifndef VGA_FRAME_CLEAR_EN
    check("busy_tied", busy, 1'b0);
    for (int i = 0; i < 14; i++) begin
      wait_cyc(pix_cyc(tbl[i].h, tbl[i].v));
      check($sformatf("tbl%0d_rgb", i), {vga_r, vga_g, vga_b}, tbl[i].rgb);
      check($sformatf("tbl%0d_blank_n", i), vga_blank_n, tbl[i].bn);
    end
`endif

    // Write the cell being read in that same clk (x=20,y=4 at h=81,v=16)
    c_wr = 2 * (16 * 800 + 81);
    wait_cyc(c_wr);
    x = 8'd20; y = 7'd4; colour = 3'b110; writeEn = 1'b1;
    @(negedge clk);
    writeEn = 1'b0;
    wait_cyc(c_wr + 2);
    check("rdwr_old", {vga_r, vga_g, vga_b}, 24'h000000);
    wait_cyc(pix_cyc(81, 17));
    check("rdwr_new", {vga_r, vga_g, vga_b}, 24'hFFFF00);

    // Reset mid-line at h=300
    wait_cyc(pix_cyc(300, 18) - 2);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("mid_rst_hs%0d", k), vga_hs, 1'b1);
      check($sformatf("mid_rst_blank_n%0d", k), vga_blank_n, 1'b0);
      check($sformatf("mid_rst_fs%0d", k), frame_start, 1'b0);
    end
    reset = 1'b1;
    @(negedge clk);
    check("mid_rel_frame_start", frame_start, 1'b1);

    first_low = -1; low_cnt = 0; vs_low = 0;
    for (int k = 2; k <= 1610; k++) begin
      wait_cyc(k);
      if (!vga_hs) begin
        low_cnt++;
        if (first_low < 0) first_low = k;
      end
      if (!vga_vs) vs_low++;
      if (k == 2)    check("line_blank_n_start", vga_blank_n, 1'b1);
      if (k == 1281) check("line_blank_n_last", vga_blank_n, 1'b1);
      if (k == 1282) check("line_blank_n_off", vga_blank_n, 1'b0);
      if (k == 1602) check("line2_blank_n_on", vga_blank_n, 1'b1);
    end
    check("hs_first_low", first_low, 1314);
    check("hs_low_width", low_cnt, 192);
    check("vs_high_line0", vs_low, 0);

`ifdef VGA_FRAME_CLEAR_EN
    guard = 0;
    while (busy && guard < 40000) begin
      @(negedge clk);
      guard++;
    end
    check("clear_done", busy, 1'b0);
    for (int yy = 0; yy < 25; yy++)
      for (int xx = 0; xx < 160; xx++) plot(8'(xx), 7'(yy), 3'b111);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("clr_rst_busy", busy, 1'b0);
    reset = 1'b1;
    bc = 0;
    for (int k = 1; k <= 19205; k++) begin
      wait_cyc(k);
      if (busy) bc++;
      if (k == 5000) plot(8'd1, 7'd4, 3'b010);
    end
    check("clr_busy_len", bc, 19200);
    nz = 0;
    for (int k = pix_cyc(0, 13); k < pix_cyc(0, 20); k++) begin
      wait_cyc(k);
      if ({vga_r, vga_g, vga_b} != 24'h0) nz++;
    end
    check("clr_black_rows", nz, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
